sr_command_debouncer: RTL and testbench

Upstream command stage for the SR flip-flop. It takes two raw, asynchronous request lines (set and reset pushbuttons or external strobes), synchronises and debounces each one, and turns each debounced rising edge into a one-cycle S or R pulse. The outputs drive the flip-flop's S_In/R_In directly. The block guarantees S and R are never asserted together, so the flip-flop's 11 race condition cannot be reached through this path.

---
 rtl/sr_command_pkg.sv | 13 +
 rtl/sr_command_debouncer_checker.sv | 15 +
 rtl/sr_command_debouncer_debounce_channel.sv | 59 +++++
 rtl/sr_command_debouncer.sv | 74 +++++++
 tb/tb_sr_command_debouncer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sr_command_pkg.sv
// Shared types and default parameters for the SR flip-flop command stage.
package sr_command_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    S_PULSE = 2'd1,
    R_PULSE = 2'd2
  } sr_cmd_state_t;

  localparam int SR_CMD_DEBOUNCE_CYCLES = 4;
  localparam int SR_CMD_SYNC_STAGES     = 2;

endpackage

// File: rtl/sr_command_debouncer_checker.sv
// Property checker for the command stage outputs; bound alongside the block.
module sr_command_debouncer_checker (
  input logic clk,
  input logic s_pulse,
  input logic r_pulse,
  input logic conflict
);

  // S and R together would drive the flip-flop into its race state.
  a_no_overlap: assert property (@(posedge clk) !(s_pulse && r_pulse));

  // A conflict flag always rides on the winning R pulse.
  a_conflict_on_r: assert property (@(posedge clk) conflict |-> r_pulse);

endmodule

// File: rtl/sr_command_debouncer_debounce_channel.sv
// One request channel: synchroniser, debounce counter, debounced level and rise strobe.
module debounce_channel
  import sr_command_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_CMD_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = SR_CMD_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic                   level_r;
  logic                   sample_s;
  logic                   toggle_s;

  assign sample_s = sync_r[SYNC_STAGES-1];
  assign level    = level_r;

  // Toggle fires on the last of DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    toggle_s = 1'b0;
    rise     = 1'b0;
    if ((sample_s != level_r) && (cnt_r == CNT_MAX)) begin
      toggle_s = 1'b1;
      rise     = ~level_r;
    end else begin
      toggle_s = 1'b0;
      rise     = 1'b0;
    end
  end

  // Synchroniser shift, saturating debounce counter and level register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r  <= {SYNC_STAGES{1'b0}};
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req};
      if (sample_s == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (toggle_s) begin
        cnt_r   <= {CW{1'b0}};
        level_r <= ~level_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_command_debouncer.sv
// Debounced set/reset command stage; converts debounced rising edges into exclusive one-cycle S/R pulses.
module sr_command_debouncer
  import sr_command_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SR_CMD_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = SR_CMD_SYNC_STAGES
) (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic Set_Req_In,
  input  logic Reset_Req_In,
  output logic S_Out,
  output logic R_Out,
  output logic Set_Level_Out,
  output logic Reset_Level_Out,
  output logic Conflict_Out
);

  sr_cmd_state_t state_r;
  sr_cmd_state_t next_s;
  logic          set_rise_s;
  logic          reset_rise_s;
  logic          conflict_r;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_set_chan (
    .clk  (Clk_In),
    .rst_n(Reset_In),
    .req  (Set_Req_In),
    .level(Set_Level_Out),
    .rise (set_rise_s)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_reset_chan (
    .clk  (Clk_In),
    .rst_n(Reset_In),
    .req  (Reset_Req_In),
    .level(Reset_Level_Out),
    .rise (reset_rise_s)
  );

  // Next state: reset request wins a tie, as that is the safe side for the flip-flop.
  always_comb begin
    next_s = IDLE;
    if (reset_rise_s) begin
      next_s = R_PULSE;
    end else if (set_rise_s) begin
      next_s = S_PULSE;
    end else begin
      next_s = IDLE;
    end
  end

  // State and conflict flag registers.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      state_r    <= IDLE;
      conflict_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      conflict_r <= set_rise_s & reset_rise_s;
    end
  end

  assign S_Out        = (state_r == S_PULSE);
  assign R_Out        = (state_r == R_PULSE);
  assign Conflict_Out = conflict_r;

endmodule

// File: tb/tb_sr_command_debouncer.sv
// Bench for sr_command_debouncer: directed timing checks plus a randomized scoreboard against a reference model.
module tb_sr_command_debouncer;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic reset_n, set_req, rst_req;
  logic s_out, r_out, set_lvl, rst_lvl, conflict;
  logic ff_q = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  sr_command_debouncer #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .Clk_In         (clk),
    .Reset_In       (reset_n),
    .Set_Req_In     (set_req),
    .Reset_Req_In   (rst_req),
    .S_Out          (s_out),
    .R_Out          (r_out),
    .Set_Level_Out  (set_lvl),
    .Reset_Level_Out(rst_lvl),
    .Conflict_Out   (conflict)
  );

  sr_command_debouncer_checker u_chk (
    .clk     (clk),
    .s_pulse (s_out),
    .r_pulse (r_out),
    .conflict(conflict)
  );

  // Downstream flip-flop fed by the DUT pulses
  always @(posedge clk) begin
    if (s_out) ff_q <= 1'b1;
    else if (r_out) ff_q <= 1'b0;
  end

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: level flips once DEB consecutive synchronised samples disagree with it.
  bit raw_h[2][HMAX];
  bit lvl[2];
  int last_chg[2];
  int n_edge;
  bit prev_s, prev_r, ref_q;

  function automatic bit sample_at(input int ch, input int m);
    if (m >= SYNC) return raw_h[ch][m - SYNC];
    return 1'b0;
  endfunction

  initial begin
    bit raw[2];
    bit rise[2];
    bit tog;
    bit es, er, ec;
    n_edge = 0; prev_s = 0; prev_r = 0; ref_q = 0;
    for (int ch = 0; ch < 2; ch++) begin lvl[ch] = 0; last_chg[ch] = -1; end
    forever begin
      @(posedge clk);
      ref_q = prev_s ? 1'b1 : (prev_r ? 1'b0 : ref_q);
      raw[0] = set_req;
      raw[1] = rst_req;
      rise[0] = 0; rise[1] = 0;
      if (!reset_n) begin
        n_edge = 0;
        for (int ch = 0; ch < 2; ch++) begin lvl[ch] = 0; last_chg[ch] = -1; end
      end else begin
        for (int ch = 0; ch < 2; ch++) begin
          raw_h[ch][n_edge] = raw[ch];
          tog = 1;
          for (int k = 0; k < DEB; k++) begin
            if ((n_edge - k) <= last_chg[ch] || sample_at(ch, n_edge - k) == lvl[ch]) tog = 0;
          end
          if (tog) begin
            rise[ch] = !lvl[ch];
            lvl[ch] = !lvl[ch];
            last_chg[ch] = n_edge;
          end
        end
        if (n_edge < HMAX - 1) n_edge++;
      end
      er = rise[1];
      es = rise[0] && !rise[1];
      ec = rise[0] && rise[1];
      exp_q.push_back({es, er, ec, lvl[0], lvl[1], ref_q});
      prev_s = es;
      prev_r = er;
    end
  end

  // Monitor: compare every presented output cycle against the scoreboard head.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard{S,R,C,SL,RL,Q}", {s_out, r_out, conflict, set_lvl, rst_lvl, ff_q}, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle(input int n);
    set_req = 0; rst_req = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 0; set_req = 1; rst_req = 1;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {1'b0, s_out, r_out, conflict, set_lvl, rst_lvl}, 6'd0);
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_reset_R", {5'd0, r_out}, {5'd0, (i == 5)});
      check("post_reset_C", {5'd0, conflict}, {5'd0, (i == 5)});
      check("post_reset_S", {5'd0, s_out}, 6'd0);
    end
    @(negedge clk);
    idle(12);

    rst_req = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("reassert_R", {4'd0, r_out, conflict}, {4'd0, (i == 5), 1'b0});
    end
    @(negedge clk);
    idle(12);

    set_req = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("held_S", {4'd0, s_out, set_lvl}, {4'd0, (i == 5), (i >= 5)});
    end
    @(negedge clk);
    idle(12);

    set_req = 1;
    repeat (3) @(negedge clk);
    set_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("glitch", {4'd0, s_out, set_lvl}, 6'd0);
    end
    @(negedge clk);
    idle(6);

    set_req = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("back_to_back", {4'd0, s_out, r_out}, {4'd0, (i == 5), (i == 6)});
      if (i == 0) begin
        @(negedge clk);
        rst_req = 1;
      end
    end
    @(negedge clk);
    idle(12);

    for (int p = 0; p < 30; p++) begin
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 5) == 0) set_req = ~set_req;
        if ($urandom_range(0, 5) == 0) rst_req = ~rst_req;
        reset_n = ((p % 10 == 9) && (c == 20)) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
      reset_n = 1;
      idle(15);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
